// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data memory.
package mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

  // A request is rejected if it asks for both ops or is not word aligned.
  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input logic [1:0] lsbs);
    return (rd & wr) | (lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: write-enable plus an always-registered read.
module sp_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem.sv
// Word-addressed data memory with request/done handshake and WAIT_STATES
// extra cycles per access; illegal requests complete with err instead.
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);

  mem_state_t        state_reg;
  logic [3:0]        cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] wdata_reg;
  mem_op_t           op_reg;
  logic              err_pend_reg;
  logic              done_reg;
  logic              err_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              rd_show_reg;

  logic              req;
  logic              req_bad;
  mem_op_t           req_op;
  logic              fire_now;
  logic              fire_wait;
  logic              fire;
  logic              access_bad;
  mem_op_t           access_op;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  assign req     = mem_read | mem_write;
  assign req_bad = req_illegal(mem_read, mem_write, addr[1:0]);
  assign req_op  = mem_write ? OP_WRITE : OP_READ;

  // The access edge is the accept edge itself with no wait states,
  // otherwise the edge where the counter steps from 1 to 0.
  assign fire_now   = NO_WAIT && (state_reg == IDLE) && req;
  assign fire_wait  = (state_reg == WAIT) && (cnt_reg == 4'd1);
  assign fire       = fire_now | fire_wait;
  assign access_bad = fire_now ? req_bad : err_pend_reg;
  assign access_op  = fire_now ? req_op : op_reg;

  // In IDLE the RAM sees the live request so a zero-wait access can hit
  // the array on its accept edge; afterwards it sees the latched copy.
  assign ram_idx   = (state_reg == IDLE) ? addr[IDX_W+1:2] : idx_reg;
  assign ram_wdata = (state_reg == IDLE) ? wdata : wdata_reg;
  assign ram_we    = rst_n & fire & ~access_bad & (access_op == OP_WRITE);

  assign unused_addr_bits = ^addr[31:IDX_W+2];

  sp_ram #(
    .DEPTH(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      op_reg       <= OP_READ;
      err_pend_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
      rd_show_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            idx_reg      <= addr[IDX_W+1:2];
            wdata_reg    <= wdata;
            op_reg       <= req_op;
            err_pend_reg <= req_bad;
            cnt_reg      <= WAIT_INIT;
            state_reg    <= NO_WAIT ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg    <= 1'b0;
          err_reg     <= 1'b0;
          rd_show_reg <= 1'b0;
          state_reg   <= IDLE;
          // Freeze the loaded word before the RAM output moves on.
          if (rd_show_reg) begin
            rdata_reg <= ram_rdata;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (fire) begin
        done_reg <= 1'b1;
        err_reg  <= access_bad;
        if (access_bad) begin
          rdata_reg   <= '0;
          rd_show_reg <= 1'b0;
        end else begin
          rd_show_reg <= (access_op == OP_READ);
        end
      end
    end
  end

  // During DONE of a good read the RAM output register is the load result.
  assign rdata = rd_show_reg ? ram_rdata : rdata_reg;
  assign done  = done_reg;
  assign err   = err_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: one instance with two wait states, one with none.
module tb_data_mem;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          chk_rdata;
    int          cycle;
  } exp_t;

  logic        clk;
  logic        rst_n     [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [31:0] rdata     [2];
  logic        done      [2];
  logic        err       [2];
  logic        busy      [2];

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  data_mem #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst_n(rst_n[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .done(done[0]),
    .err(err[0]), .busy(busy[0])
  );

  data_mem #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut_zw (
    .clk(clk), .rst_n(rst_n[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .done(done[1]),
    .err(err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access: drive in cycle 0, expect done in cycle ws+1, then drop.
  task automatic do_access(input int d, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input bit exp_err, input logic [31:0] exp_rd,
                           input bit chk_rd, input bit mid,
                           input logic [31:0] a2, input logic [31:0] wd2,
                           input string name);
    int   ws;
    bit   got;
    exp_t e;
    ws = (d == 0) ? 2 : 0;
    sb.push_back('{err: exp_err, rdata: exp_rd, chk_rdata: chk_rd, cycle: ws + 1});
    @(posedge clk);
    #1;
    mem_read[d]  = rd;
    mem_write[d] = wr;
    addr[d]      = a;
    wdata[d]     = wd;
    got = 1'b0;
    for (int c = 0; c <= ws + 6 && !got; c++) begin
      @(negedge clk);
      if (c <= ws + 1) begin
        checks++;
        if (busy[d] !== (c != 0)) begin
          errors++;
          $display("FAIL %s busy c%0d: got %b want %b", name, c, busy[d], (c != 0));
        end
      end
      if (mid && c == 1) begin
        addr[d]  = a2;
        wdata[d] = wd2;
      end
      if (done[d] === 1'b1) begin
        got = 1'b1;
        e = sb.pop_front();
        $display("txn %s: inst %0d done cycle %0d err %b rdata %h", name, d, c, err[d], rdata[d]);
        checks++;
        if (c != e.cycle) begin
          errors++;
          $display("FAIL %s latency: got cycle %0d want %0d", name, c, e.cycle);
        end
        checks++;
        if (err[d] !== e.err) begin
          errors++;
          $display("FAIL %s err: got %b want %b", name, err[d], e.err);
        end
        if (e.chk_rdata) begin
          checks++;
          if (rdata[d] !== e.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", name, rdata[d], e.rdata);
          end
        end
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      void'(sb.pop_front());
      $display("FAIL %s timeout: got no done want done in cycle %0d", name, ws + 1);
      mem_read[d]  = 1'b0;
      mem_write[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks += 4;
      if (done[d] !== 1'b0) begin errors++; $display("FAIL reset done inst %0d: got %b want 0", d, done[d]); end
      if (err[d] !== 1'b0) begin errors++; $display("FAIL reset err inst %0d: got %b want 0", d, err[d]); end
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset busy inst %0d: got %b want 0", d, busy[d]); end
      if (rdata[d] !== 32'h0) begin errors++; $display("FAIL reset rdata inst %0d: got %h want 0", d, rdata[d]); end
      $display("txn reset: inst %0d outputs done %b err %b busy %b rdata %h", d, done[d], err[d], busy[d], rdata[d]);
    end
  endtask

  task automatic test_basic();
    do_access(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, '0, 0, 0, '0, '0, "basic_wr");
    do_access(0, 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1, 0, '0, '0, "basic_rd");
  endtask

  task automatic test_alias();
    do_access(0, 0, 1, 32'h400, 32'h12345678, 0, '0, 0, 0, '0, '0, "alias_wr");
    do_access(0, 1, 0, 32'h000, 32'h0, 0, 32'h12345678, 1, 0, '0, '0, "alias_rd");
  endtask

  task automatic test_illegal();
    do_access(0, 1, 0, 32'h13, 32'h0, 1, 32'h0, 1, 0, '0, '0, "misaligned_rd");
    do_access(0, 0, 1, 32'h20, 32'hCAFEF00D, 0, '0, 0, 0, '0, '0, "pre_wr");
    do_access(0, 1, 1, 32'h20, 32'h11111111, 1, 32'h0, 1, 0, '0, '0, "both_ops");
    do_access(0, 1, 0, 32'h20, 32'h0, 0, 32'hCAFEF00D, 1, 0, '0, '0, "both_ops_rd");
  endtask

  task automatic test_rdata_hold();
    do_access(0, 0, 1, 32'h24, 32'h24242424, 0, 32'hCAFEF00D, 1, 0, '0, '0, "hold_wr");
  endtask

  task automatic test_mid_change();
    do_access(0, 0, 1, 32'h48, 32'h48484848, 0, '0, 0, 0, '0, '0, "mid_pre_wr");
    do_access(0, 0, 1, 32'h40, 32'hA0A0A0A0, 0, '0, 0, 1, 32'h48, 32'hBBBBBBBB, "mid_wr");
    do_access(0, 1, 0, 32'h40, 32'h0, 0, 32'hA0A0A0A0, 1, 0, '0, '0, "mid_rd40");
    do_access(0, 1, 0, 32'h48, 32'h0, 0, 32'h48484848, 1, 0, '0, '0, "mid_rd48");
  endtask

  task automatic test_reset_mid();
    do_access(0, 0, 1, 32'h44, 32'h0BADCAFE, 0, '0, 0, 0, '0, '0, "rst_pre_wr");
    @(posedge clk);
    #1;
    mem_write[0] = 1'b1; addr[0] = 32'h44; wdata[0] = 32'hFFFF0000;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    mem_write[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(negedge clk);
    checks += 4;
    if (done[0] !== 1'b0) begin errors++; $display("FAIL rst_mid done: got %b want 0", done[0]); end
    if (err[0] !== 1'b0) begin errors++; $display("FAIL rst_mid err: got %b want 0", err[0]); end
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b want 0", busy[0]); end
    if (rdata[0] !== 32'h0) begin errors++; $display("FAIL rst_mid rdata: got %h want 0", rdata[0]); end
    $display("txn rst_mid: outputs after reset done %b err %b busy %b rdata %h", done[0], err[0], busy[0], rdata[0]);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (done[0] !== 1'b0) begin errors++; $display("FAIL rst_mid late done c%0d: got %b want 0", c, done[0]); end
    end
    do_access(0, 1, 0, 32'h44, 32'h0, 0, 32'h0BADCAFE, 1, 0, '0, '0, "rst_mid_rd");
  endtask

  // Zero wait states: held write replaced by a read the moment done shows.
  task automatic test_back_to_back();
    exp_t e;
    int   n;
    sb.push_back('{err: 1'b0, rdata: 32'h0, chk_rdata: 1'b0, cycle: 1});
    sb.push_back('{err: 1'b0, rdata: 32'h55AA0000, chk_rdata: 1'b1, cycle: 3});
    n = 0;
    @(posedge clk);
    #1;
    mem_write[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'h55AA0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (busy[1] !== (c == 1 || c == 3)) begin
        errors++;
        $display("FAIL b2b busy c%0d: got %b want %b", c, busy[1], (c == 1 || c == 3));
      end
      if (done[1] === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn b2b_%0d: inst 1 done cycle %0d err %b rdata %h", n, c, err[1], rdata[1]);
        checks += 2;
        if (c != e.cycle) begin errors++; $display("FAIL b2b_%0d latency: got cycle %0d want %0d", n, c, e.cycle); end
        if (err[1] !== e.err) begin errors++; $display("FAIL b2b_%0d err: got %b want %b", n, err[1], e.err); end
        if (e.chk_rdata) begin
          checks++;
          if (rdata[1] !== e.rdata) begin errors++; $display("FAIL b2b_%0d rdata: got %h want %h", n, rdata[1], e.rdata); end
        end
        if (n == 0) begin
          mem_write[1] = 1'b0; mem_read[1] = 1'b1; addr[1] = 32'h8;
        end else begin
          mem_read[1] = 1'b0;
        end
        n++;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL b2b count: got %0d dones want 2", n);
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alias();
    test_illegal();
    test_rdata_hold();
    test_mid_change();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Word-addressed data memory that services the load/store requests produced by the main control decoder (`mem_read`, `mem_write`). It sits in the MEM stage between the ALU result and the write-back mux. It uses a request/done handshake with a configurable number of wait states so that the pipeline stalls until the access completes. Illegal requests are detected and reported rather than performed.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, at least 2.
- `WAIT_STATES`, default 2: extra cycles per access; range 0–15.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `mem_read`  in  1  load request; held until `done`.
- `mem_write`  in  1  store request; held until `done`.
- `addr`  in  32  byte address from the ALU.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data; valid while `done`=1.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: the request was rejected.
- `busy`  out  1  high whenever state≠IDLE.

## Operation
- State machine IDLE → WAIT → DONE → IDLE.
- **IDLE**
  - A request is `mem_read | mem_write` sampled high at a rising edge.
  - On a request, latch `addr`, `wdata` and the op, and load the counter with `WAIT_STATES`.
  - Next state is WAIT, or DONE if `WAIT_STATES`=0.
- **WAIT**
  - Counter decrements each cycle.
  - At the edge where the counter reaches 0, perform the access and go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- **Access**
  - Word index is `addr[$clog2(DEPTH_WORDS)+1:2]`; upper bits are ignored, so addresses alias/wrap modulo `4*DEPTH_WORDS`.
  - A write stores `wdata` at the index.
  - A read registers the array word into `rdata`. `rdata` holds until the next completed read, error, or reset.
- **Errors**, detected at accept:
  - Both `mem_read` and `mem_write` high, or `addr[1:0]`≠0.
  - The access is skipped, `rdata` is set to 0, and `err`=1 with `done`.
  - Error latency equals normal latency.
- Request inputs are ignored outside IDLE, including changes mid-access.
- A request still held in the cycle after `done` (state IDLE) is treated as a new access. The requester drops or replaces its request when it sees `done`.

## Timing
- **Reset values:**
  - State IDLE, counter 0.
  - `done`=0, `err`=0, `busy`=0, `rdata`=0.
  - Array contents are not reset.
- **Latency:**
  - Request sampled in cycle 0, `done` high in cycle `WAIT_STATES`+1.
  - Throughput is one access per `WAIT_STATES`+2 cycles.
- **`busy` timing:** `busy` rises in cycle 1 and falls in the cycle after `done`. The pipeline stall is `request & ~done`.
- **Reset mid-access:** return to IDLE with no memory write and no `done`. The array is unchanged if reset occurs on or before the write edge.
- **Outputs:** `done`, `err` and `rdata` are registered. `busy` is decoded from the state register. There is no combinational path from inputs to outputs.

## Structure
- **Package `mem_pkg`:**
  - `mem_state_t` enum (IDLE, WAIT, DONE).
  - `mem_op_t` enum (OP_READ, OP_WRITE).
  - Constants `WORD_BYTES`=4 and `DATA_W`=32.
- **Sub-module `sp_ram`:**
  - Single-port synchronous RAM.
  - Ports: `clk`, `we`, `idx`, `wdata`, `rdata`.
  - Parameter `DEPTH`.
  - `data_mem` holds the FSM, counter, latches and error checks.

## Test plan
- **Basic write/read, `WAIT_STATES`=2:** write 0xDEADBEEF to 0x10, then read 0x10. Each access gives `done` in cycle 3 with `err`=0; the read returns `rdata`=0xDEADBEEF.
- **Aliasing, `DEPTH_WORDS`=256:** write 0x12345678 to 0x400, then read 0x000 → 0x12345678.
- **Illegal requests:**
  - Read at 0x13 → `done`=1, `err`=1, `rdata`=0.
  - `mem_read` and `mem_write` both high at 0x20 → `err`=1, and a later read of 0x20 returns the old word.
- **Zero wait states, `WAIT_STATES`=0:** back-to-back held write then read → `done` in cycle 1, one access per 2 cycles. `busy` is 0 in request cycles and 1 in DONE.
- **Mid-access changes and reset:**
  - A write to 0x40 with `addr`/`wdata` changed during WAIT stores the originally latched values.
  - Reset asserted in the first WAIT cycle of a write to 0x44 → no `done`, the word at 0x44 is unchanged, and all outputs are 0 the cycle after reset.
